// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add WIDTH x WIDTH multiplier with valid/ready handshakes
// Ports: clk, rst (async active-low); operand side in_valid/in_ready/input_a/input_b/in_signed;
//        result side out_valid/out_ready/output_z (full 2*WIDTH product).
// SEQ_MUL_SIGNED_EN: when defined, in_signed selects two's complement operands; otherwise all unsigned.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] output_z
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]         r_state, w_next;
  logic [2*WIDTH-1:0] r_acc, r_mcand, r_z, w_sum, w_res;
  logic [WIDTH-1:0]   r_mplier, w_a_mag, w_b_mag;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept, w_last;
  assign w_accept = in_valid && r_state == IDLE;
  assign w_last   = r_cnt == CNT_W'(WIDTH-1);
  assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign output_z = r_z;
`ifdef SEQ_MUL_SIGNED_EN
  logic r_neg;
  // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
  assign w_a_mag = in_signed && input_a[WIDTH-1] ? -input_a : input_a;
  assign w_b_mag = in_signed && input_b[WIDTH-1] ? -input_b : input_b;
  assign w_res   = r_neg ? -w_sum : w_sum;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_neg <= 1'b0;
    else if (w_accept) r_neg <= in_signed & (input_a[WIDTH-1] ^ input_b[WIDTH-1]);
`else
  logic w_unused;
  assign w_unused = in_signed;
  assign w_a_mag  = input_a;
  assign w_b_mag  = input_b;
  assign w_res    = w_sum;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (in_valid ? BUSY : IDLE) :
             r_state == BUSY ? (w_last ? DONE : BUSY) :
             (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_z      <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_cnt    <= '0;
    end else if (r_state == BUSY) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) r_z <= w_res;
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of seq_multiplier against a cycle-level transaction model
module tb_seq_multiplier;
  localparam int W = 32;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
  logic [W-1:0]  input_a = '0, input_b = '0;
  logic          in_ready, out_valid;
  logic [2*W-1:0] output_z;
  int n_chk = 0, n_fail = 0;
  logic chk_en = 1'b0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .input_b(input_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .output_z(output_z)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [W-1:0] a, b, input logic s);
`ifdef SEQ_MUL_SIGNED_EN
    if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
`endif
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // transaction model: a product becomes visible exactly W edges after acceptance
  int m_cyc = 0, m_due = 0;
  logic m_busy = 1'b0, m_done = 1'b0;
  logic [63:0] m_z = '0, m_pend = '0;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_z = '0; m_cyc = 0;
    end else begin
      m_cyc++;
      if (m_done) begin
        if (out_ready) m_done = 1'b0;
      end else if (m_busy) begin
        if (m_cyc == m_due) begin m_busy = 1'b0; m_done = 1'b1; m_z = m_pend; end
      end else if (in_valid) begin
        m_busy = 1'b1; m_due = m_cyc + W; m_pend = prod(input_a, input_b, in_signed);
      end
    end

  always @(negedge clk)
    if (chk_en) begin
      chk("model in_ready", {63'b0, in_ready}, {63'b0, !m_busy && !m_done});
      chk("model out_valid", {63'b0, out_valid}, {63'b0, m_done});
      chk("model output_z", output_z, m_z);
    end

  task automatic run(input logic [W-1:0] a, b, input logic s, input logic [63:0] exp, input string name);
    int n;
    in_valid = 1'b1; input_a = a; input_b = b; in_signed = s;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk({name, " accept wait"}, {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; input_a = $urandom; input_b = $urandom; in_signed = 1'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk({name, " latency"}, 64'(n), 64'(W));
    chk({name, " product"}, output_z, exp);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({name, " in_ready after handshake"}, {63'b0, in_ready}, 64'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset in_ready", {63'b0, in_ready}, 64'd1);
    chk("reset out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset output_z", output_z, 64'd0);
    @(posedge clk); #1;

    run(32'd3, 32'd5, 1'b0, 64'd15, "3x5");
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "max unsigned");
`ifdef SEQ_MUL_SIGNED_EN
    run(32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1, "-3x5");
    run(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, "minint sq");
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1, "-1x-1");
    run(32'hFFFFFFFD, 32'd5, 1'b0, 64'h00000004FFFFFFF1, "-3x5 unsigned mode");
`else
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE00000001, "max signed ignored");
    run(32'hFFFFFFFD, 32'd5, 1'b1, 64'h00000004FFFFFFF1, "-3x5 signed ignored");
`endif

    out_ready = 1'b0;
    in_valid = 1'b1; input_a = 32'd2; input_b = 32'd3; in_signed = 1'b0;
    @(posedge clk); #1;
    input_a = 32'd4; input_b = 32'd5;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp first product", output_z, 64'd6);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp out_valid held", {63'b0, out_valid}, 64'd1);
      chk("bp output_z held", output_z, 64'd6);
      chk("bp in_ready low", {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp released in_ready", {63'b0, in_ready}, 64'd1);
    chk("bp released out_valid", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp second accepted", {63'b0, in_ready}, 64'd0);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp second latency", 64'(n), 64'(W));
    chk("bp second product", output_z, 64'd20);
    @(posedge clk); #1;

    in_valid = 1'b1; input_a = 32'd1234; input_b = 32'd5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort out_valid", {63'b0, out_valid}, 64'd0);
    chk("abort output_z", output_z, 64'd0);
    chk("abort in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    run(32'd7, 32'd6, 1'b0, 64'd42, "7x6 after abort");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
